i2c_secondary_multibyte: RTL



---
 rtl/i2c_secondary_multibyte.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_secondary_multibyte.sv
// I2C secondary (target) with a 7-bit address and an NBYTES-byte payload.
//
// The bus is modelled as separate lines. The primary's drive is SDA_OUT
// qualified by SDA_OE, and a released line reads as 1. This secondary drives
// SDA_IN, where 0 pulls the line low and 1 releases it.
//
// Ports:
//   CLK        system clock; all logic runs on the rising edge
//   RESET      synchronous, active-high reset
//   SCL        bus clock from the primary
//   SDA_OUT    primary SDA drive value
//   SDA_OE     primary SDA output enable (0 = released, reads as 1)
//   I2CS_ADDR  this secondary's 7-bit address
//   RDS_DATA   read payload, byte 0 in the MSBs
//   SDA_IN     secondary SDA drive (0 = pull low, 1 = release), registered
//   WRS_DATA   last complete write payload, byte 0 in the MSBs, registered
//   WR_VALID   one-cycle pulse when WRS_DATA updates
//   RD_STROBE  one-cycle pulse when RDS_DATA is snapshotted
//   BUSY       high from address match until the next START or STOP
//
// Local-side interface: there is no backpressure. WR_VALID is high for
// exactly one CLK, in the same cycle that WRS_DATA first shows the new
// payload. RD_STROBE is high for exactly one CLK, in the cycle after
// RDS_DATA was captured. After that capture, RDS_DATA may change freely.
//
// The FSM state and both counters live in the packed struct fsm_q so that
// checkers can bind to a single signal.
module i2c_secondary_multibyte #(
  parameter int NBYTES = 2,
  parameter int ADDR_W = 7
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SCL,
  input  logic                  SDA_OUT,
  input  logic                  SDA_OE,
  input  logic [ADDR_W-1:0]     I2CS_ADDR,
  input  logic [8*NBYTES-1:0]   RDS_DATA,
  output logic                  SDA_IN,
  output logic [8*NBYTES-1:0]   WRS_DATA,
  output logic                  WR_VALID,
  output logic                  RD_STROBE,
  output logic                  BUSY
);

  localparam int DW  = 8 * NBYTES;
  localparam int BCW = $clog2(NBYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
  } state_t;

  typedef struct packed {
    state_t         state;
    logic [2:0]     bit_cnt;
    logic [BCW-1:0] byte_cnt;
    logic           bit_seen;  // an SCL rise occurred since the last SCL fall
  } fsm_t;

  fsm_t           fsm_q, fsm_d;
  logic           scl_q, p_q;
  logic [7:0]     sr_q, sr_d;
  logic [DW-1:0]  shadow_q, shadow_d;
  logic [DW-1:0]  snap_q, snap_d;
  logic           ack_q, ack_d;
  logic           sda_q, sda_d;
  logic [DW-1:0]  wrs_q, wrs_d;
  logic           wr_valid_q, wr_valid_d;
  logic           rd_strobe_q, rd_strobe_d;
  logic           busy_q, busy_d;

  logic           p;
  logic           scl_rise, scl_fall, start_det, stop_det;
  logic [BCW-1:0] next_idx;
  logic [7:0]     cur_byte, nxt_byte;

  function automatic logic [7:0] get_byte(input logic [DW-1:0] v, input logic [BCW-1:0] idx);
    logic [7:0] r;
    r = v[DW-1 -: 8];
    for (int k = 0; k < NBYTES; k++)
      if (int'(idx) == k) r = v[DW-1-8*k -: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] v, input logic [BCW-1:0] idx,
                                             input logic [7:0] b);
    logic [DW-1:0] r;
    r = v;
    for (int k = 0; k < NBYTES; k++)
      if (int'(idx) == k) r[DW-1-8*k -: 8] = b;
    return r;
  endfunction

  assign p         = SDA_OE ? SDA_OUT : 1'b1;
  assign scl_rise  = SCL & ~scl_q;
  assign scl_fall  = ~SCL & scl_q;
  assign start_det = SCL & scl_q & p_q & ~p;
  assign stop_det  = SCL & scl_q & ~p_q & p;

  // After a read ACK the byte index wraps, so the snapshot is resent.
  assign next_idx = (int'(fsm_q.byte_cnt) == NBYTES - 1) ? '0 : fsm_q.byte_cnt + BCW'(1);
  assign cur_byte = get_byte(snap_q, fsm_q.byte_cnt);
  assign nxt_byte = get_byte(snap_q, next_idx);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      scl_q             <= 1'b1;
      p_q               <= 1'b1;
      fsm_q.state       <= S_IDLE;
      fsm_q.bit_cnt     <= '0;
      fsm_q.byte_cnt    <= '0;
      fsm_q.bit_seen    <= 1'b0;
      sr_q              <= '0;
      shadow_q          <= '0;
      snap_q            <= '0;
      ack_q             <= 1'b1;
      sda_q             <= 1'b1;
      wrs_q             <= '0;
      wr_valid_q        <= 1'b0;
      rd_strobe_q       <= 1'b0;
      busy_q            <= 1'b0;
    end else begin
      scl_q             <= SCL;
      p_q               <= p;
      fsm_q             <= fsm_d;
      sr_q              <= sr_d;
      shadow_q          <= shadow_d;
      snap_q            <= snap_d;
      ack_q             <= ack_d;
      sda_q             <= sda_d;
      wrs_q             <= wrs_d;
      wr_valid_q        <= wr_valid_d;
      rd_strobe_q       <= rd_strobe_d;
      busy_q            <= busy_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    sr_d        = sr_q;
    shadow_d    = shadow_q;
    snap_d      = snap_q;
    ack_d       = ack_q;
    sda_d       = sda_q;
    wrs_d       = wrs_q;
    wr_valid_d  = 1'b0;
    rd_strobe_d = 1'b0;
    busy_d      = busy_q;

    if (start_det) begin
      fsm_d.state    = S_ADDR;
      fsm_d.bit_cnt  = '0;
      fsm_d.byte_cnt = '0;
      fsm_d.bit_seen = 1'b0;  // the SCL fall that follows START carries no bit
      sda_d          = 1'b1;
      busy_d         = 1'b0;
    end else if (stop_det) begin
      fsm_d.state    = S_IDLE;
      sda_d          = 1'b1;
      busy_d         = 1'b0;
    end else begin
      if (scl_rise)      fsm_d.bit_seen = 1'b1;
      else if (scl_fall) fsm_d.bit_seen = 1'b0;

      case (fsm_q.state)
        S_ADDR: begin
          if (scl_rise) sr_d = {sr_q[6:0], p};
          if (scl_fall && fsm_q.bit_seen) begin
            if (fsm_q.bit_cnt == 3'd7) begin
              fsm_d.bit_cnt = '0;
              if (sr_q[7:1] == I2CS_ADDR) begin
                sda_d       = 1'b0;
                busy_d      = 1'b1;
                fsm_d.state = S_ADDR_ACK;
              end else begin
                sda_d       = 1'b1;
                fsm_d.state = S_WAIT_STOP;
              end
            end else begin
              fsm_d.bit_cnt = fsm_q.bit_cnt + 3'd1;
            end
          end
        end

        // sr_q still holds the address byte here; its LSB is R/nW.
        S_ADDR_ACK: begin
          if (scl_fall && fsm_q.bit_seen) begin
            fsm_d.bit_cnt  = '0;
            fsm_d.byte_cnt = '0;
            if (!sr_q[0]) begin
              sda_d       = 1'b1;
              fsm_d.state = S_WR_DATA;
            end else begin
              snap_d      = RDS_DATA;
              rd_strobe_d = 1'b1;
              sda_d       = RDS_DATA[DW-1];
              fsm_d.state = S_RD_DATA;
            end
          end
        end

        S_WR_DATA: begin
          if (scl_rise) sr_d = {sr_q[6:0], p};
          if (scl_fall && fsm_q.bit_seen) begin
            if (fsm_q.bit_cnt == 3'd7) begin
              fsm_d.bit_cnt = '0;
              if (int'(fsm_q.byte_cnt) < NBYTES) begin
                shadow_d    = put_byte(shadow_q, fsm_q.byte_cnt, sr_q);
                sda_d       = 1'b0;
                fsm_d.state = S_WR_ACK;
              end else begin
                // One byte more than the payload holds: NACK it.
                sda_d       = 1'b1;
                fsm_d.state = S_WAIT_STOP;
              end
            end else begin
              fsm_d.bit_cnt = fsm_q.bit_cnt + 3'd1;
            end
          end
        end

        S_WR_ACK: begin
          if (scl_fall && fsm_q.bit_seen) begin
            sda_d          = 1'b1;
            fsm_d.byte_cnt = fsm_q.byte_cnt + BCW'(1);
            fsm_d.state    = S_WR_DATA;
            if (int'(fsm_q.byte_cnt) == NBYTES - 1) begin
              wrs_d      = shadow_q;
              wr_valid_d = 1'b1;
            end
          end
        end

        // bit_cnt counts the bits already on the line; bit (7 - bit_cnt) is
        // being driven now.
        S_RD_DATA: begin
          if (scl_fall && fsm_q.bit_seen) begin
            if (fsm_q.bit_cnt == 3'd7) begin
              fsm_d.bit_cnt = '0;
              sda_d         = 1'b1;
              fsm_d.state   = S_RD_ACK;
            end else begin
              fsm_d.bit_cnt = fsm_q.bit_cnt + 3'd1;
              sda_d         = cur_byte[3'd6 - fsm_q.bit_cnt];
            end
          end
        end

        S_RD_ACK: begin
          if (scl_rise) ack_d = p;
          if (scl_fall && fsm_q.bit_seen) begin
            if (!ack_q) begin
              fsm_d.byte_cnt = next_idx;
              fsm_d.bit_cnt  = '0;
              sda_d          = nxt_byte[7];
              fsm_d.state    = S_RD_DATA;
            end else begin
              sda_d       = 1'b1;
              fsm_d.state = S_WAIT_STOP;
            end
          end
        end

        S_WAIT_STOP: sda_d = 1'b1;

        default: ;
      endcase
    end
  end

  assign SDA_IN    = sda_q;
  assign WRS_DATA  = wrs_q;
  assign WR_VALID  = wr_valid_q;
  assign RD_STROBE = rd_strobe_q;
  assign BUSY      = busy_q;

endmodule
